// File: rtl/key_repeat_conditioner.sv
// Two-button front end for the packet-injection selector: synchronise, debounce,
// then turn each press into single-cycle pulses with auto-repeat while held.
module key_repeat_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw_inc,
    input  logic key_raw_dec,
    output logic key_inc,
    output logic key_dec,
    output logic held_inc,
    output logic held_dec,
    output logic conflict
);

    localparam int unsigned DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = (REPEAT_PERIOD > 0) ? RW'(REPEAT_PERIOD - 1) : '0;
    localparam bit            REPEAT_EN = (REPEAT_PERIOD != 0);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, BLOCKED} state_t;

    logic [1:0] raw_pressed;
    logic [1:0] db_vec;
    logic [1:0] db_next_vec;
    logic [1:0] pulse_vec;
    logic       conflict_q, conflict_d;

    assign raw_pressed = {key_raw_dec, key_raw_inc} ^ {2{ACTIVE_LOW}};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        localparam int OTHER = 1 - ch;

        logic          norm_q, norm_d;
        logic          sync1_q, sync1_d;
        logic          s_q, s_d;
        logic          db_q, db_d;
        logic [DW-1:0] dcnt_q, dcnt_d;
        state_t        state_q;
        logic [RW-1:0] rcnt_q;
        logic          pulse_q;
        logic          own, other;

        // Registered normalise stage ahead of the two-flop synchroniser.
        always_comb begin
            norm_d  = raw_pressed[ch];
            sync1_d = norm_q;
            s_d     = sync1_q;
            db_d    = db_q;
            dcnt_d  = '0;
            if (s_q != db_q) begin
                if (dcnt_q == DB_LAST) begin
                    db_d = ~db_q;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                norm_q  <= 1'b0;
                sync1_q <= 1'b0;
                s_q     <= 1'b0;
                db_q    <= 1'b0;
                dcnt_q  <= '0;
            end else begin
                norm_q  <= norm_d;
                sync1_q <= sync1_d;
                s_q     <= s_d;
                db_q    <= db_d;
                dcnt_q  <= dcnt_d;
            end
        end

        assign db_vec[ch]      = db_q;
        assign db_next_vec[ch] = db_d;
        assign pulse_vec[ch]   = pulse_q;
        assign own             = db_q;
        assign other           = db_vec[OTHER];

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                rcnt_q  <= '0;
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (own) begin
                            rcnt_q <= '0;
                            if (other) begin
                                state_q <= BLOCKED;
                            end else begin
                                pulse_q <= 1'b1;
                                state_q <= DELAY;
                            end
                        end
                    end
                    DELAY: begin
                        if (!own) begin
                            state_q <= IDLE;
                        end else if (other) begin
                            state_q <= BLOCKED;
                        end else if (rcnt_q == RD_LAST) begin
                            // With repeat disabled the counter simply parks here.
                            if (REPEAT_EN) begin
                                pulse_q <= 1'b1;
                                state_q <= REPEAT;
                                rcnt_q  <= '0;
                            end
                        end else begin
                            rcnt_q <= rcnt_q + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (!own) begin
                            state_q <= IDLE;
                        end else if (other) begin
                            state_q <= BLOCKED;
                        end else if (rcnt_q == RP_LAST) begin
                            pulse_q <= 1'b1;
                            rcnt_q  <= '0;
                        end else begin
                            rcnt_q <= rcnt_q + 1'b1;
                        end
                    end
                    default: begin
                        if (!own) begin
                            state_q <= IDLE;
                        end else if (!other) begin
                            state_q <= DELAY;
                            rcnt_q  <= '0;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        conflict_d = db_next_vec[0] & db_next_vec[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign key_inc  = pulse_vec[0];
    assign key_dec  = pulse_vec[1];
    assign held_inc = db_vec[0];
    assign held_dec = db_vec[1];
    assign conflict = conflict_q;

endmodule

// File: tb/tb_key_repeat_conditioner.sv
// Bench for key_repeat_conditioner: directed scenarios plus random key activity,
// compared every cycle against a timestamp-based reference model.
module tb_key_repeat_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    localparam int M_IDLE    = 0;
    localparam int M_ACTIVE  = 1;
    localparam int M_BLOCKED = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_raw_inc = 1'b1;
    logic key_raw_dec = 1'b1;
    logic ki3, kd3, hi3, hd3, cf3;
    logic ki0, kd0, hi0, hd0, cf0;

    int total = 0;
    int bad   = 0;
    int tc    = 0;
    int cnt_i3, cnt_d3, cnt_i0, cnt_d0;
    int mcnt_d3;
    int h_seen;
    int dq[$];

    always #5 clk = ~clk;

    key_repeat_conditioner #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .ACTIVE_LOW(1'b1)
    ) u_dut (
        .clk(clk), .rst(rst), .key_raw_inc(key_raw_inc), .key_raw_dec(key_raw_dec),
        .key_inc(ki3), .key_dec(kd3), .held_inc(hi3), .held_dec(hd3), .conflict(cf3)
    );

    key_repeat_conditioner #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(0), .ACTIVE_LOW(1'b1)
    ) u_dut_norep (
        .clk(clk), .rst(rst), .key_raw_inc(key_raw_inc), .key_raw_dec(key_raw_dec),
        .key_inc(ki0), .key_dec(kd0), .held_inc(hi0), .held_dec(hd0), .conflict(cf0)
    );

    typedef struct {
        bit [2:0] hist;   // pressed samples at edges k-1, k-2, k-3
        bit       db;
        int       run;
        int       mode;
        int       start;
        bit       pulse;
    } ch_t;

    typedef struct {
        ch_t inc;
        ch_t dec;
        bit  conflict;
        int  k;
    } mdl_t;

    mdl_t m3, m0;

    function automatic ch_t ch_reset();
        ch_t c;
        c.hist = '0; c.db = 1'b0; c.run = 0; c.mode = M_IDLE; c.start = 0; c.pulse = 1'b0;
        return c;
    endfunction

    // Pulses fall at fixed offsets from the moment a key became the sole held key.
    function automatic ch_t fsm_step(ch_t c, bit other, int k, int rp);
        ch_t n = c;
        int t;
        n.pulse = 1'b0;
        if (c.mode == M_IDLE) begin
            if (c.db) begin
                if (other) n.mode = M_BLOCKED;
                else begin n.mode = M_ACTIVE; n.start = k; n.pulse = 1'b1; end
            end
        end else if (!c.db) begin
            n.mode = M_IDLE;
        end else if (c.mode == M_ACTIVE) begin
            if (other) n.mode = M_BLOCKED;
            else begin
                t = k - c.start;
                if (rp != 0 && (t == RD || (t > RD && (t - RD) % rp == 0))) n.pulse = 1'b1;
            end
        end else if (!other) begin
            n.mode = M_ACTIVE; n.start = k;
        end
        return n;
    endfunction

    function automatic ch_t db_step(ch_t c, bit pressed);
        ch_t n = c;
        if (c.hist[2] == c.db) n.run = 0;
        else begin
            n.run = c.run + 1;
            if (n.run == D) begin n.db = ~c.db; n.run = 0; end
        end
        n.hist = {c.hist[1:0], pressed};
        return n;
    endfunction

    function automatic mdl_t step(mdl_t m, bit r, bit ri, bit rd, int rp);
        mdl_t n;
        n.k = m.k + 1;
        if (r) begin
            n.inc = ch_reset(); n.dec = ch_reset(); n.conflict = 1'b0;
            return n;
        end
        n.inc = db_step(fsm_step(m.inc, m.dec.db, m.k, rp), ~ri);
        n.dec = db_step(fsm_step(m.dec, m.inc.db, m.k, rp), ~rd);
        n.conflict = n.inc.db & n.dec.db;
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, tc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m3 = step(m3, rst, key_raw_inc, key_raw_dec, RP);
        m0 = step(m0, rst, key_raw_inc, key_raw_dec, 0);
        @(negedge clk);
        tc++;
        check("p3.key_inc",  ki3, m3.inc.pulse);
        check("p3.key_dec",  kd3, m3.dec.pulse);
        check("p3.held_inc", hi3, m3.inc.db);
        check("p3.held_dec", hd3, m3.dec.db);
        check("p3.conflict", cf3, m3.conflict);
        check("p0.key_inc",  ki0, m0.inc.pulse);
        check("p0.key_dec",  kd0, m0.dec.pulse);
        check("p0.held_inc", hi0, m0.inc.db);
        check("p0.held_dec", hd0, m0.dec.db);
        check("p0.conflict", cf0, m0.conflict);
        check("p3.exclusive", ki3 & kd3, 0);
        if (ki3) cnt_i3++;
        if (kd3) begin cnt_d3++; dq.push_back(tc); end
        if (ki0) cnt_i0++;
        if (kd0) cnt_d0++;
        if (m3.dec.pulse) mcnt_d3++;
        if (hi3) h_seen = 1;
    endtask

    task automatic clear_counts();
        cnt_i3 = 0; cnt_d3 = 0; cnt_i0 = 0; cnt_d0 = 0; mcnt_d3 = 0; h_seen = 0;
        dq.delete();
    endtask

    initial begin
        int t_r, t_c, t_p;
        m3.inc = ch_reset(); m3.dec = ch_reset(); m3.conflict = 1'b0; m3.k = 0;
        m0 = m3;
        clear_counts();

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst.key_inc", ki3, 0);
        check("rst.held_inc", hi3, 0);
        check("rst.conflict", cf3, 0);
        rst = 1'b0;
        repeat (5) tick();

        // 1: single press, latency and one pulse
        clear_counts();
        key_raw_inc = 1'b0;
        repeat (6) tick();
        check("s1.held_before", hi3, 0);
        tick();
        check("s1.held_at_t6", hi3, 1);
        check("s1.no_pulse_yet", ki3, 0);
        tick();
        check("s1.pulse_at_t7", ki3, 1);
        key_raw_inc = 1'b1;
        repeat (20) tick();
        check("s1.inc_pulses", cnt_i3, 1);
        check("s1.dec_pulses", cnt_d3, 0);

        // 2: glitch shorter than the debounce window
        clear_counts();
        key_raw_inc = 1'b0;
        repeat (3) tick();
        key_raw_inc = 1'b1;
        repeat (15) tick();
        check("s2.held_seen", h_seen, 0);
        check("s2.pulses", cnt_i3, 0);

        // 3 and 6: long hold on dec with auto-repeat, and with repeat disabled
        clear_counts();
        key_raw_dec = 1'b0;
        repeat (40) tick();
        key_raw_dec = 1'b1;
        repeat (20) tick();
        check("s3.pulses", cnt_d3, mcnt_d3);
        check("s3.enough_pulses", cnt_d3 >= 3, 1);
        check("s3.first_gap", dq[1] - dq[0], RD);
        check("s3.repeat_gap", dq[2] - dq[1], RP);
        check("s6.norep_pulses", cnt_d0, 1);

        clear_counts();
        key_raw_inc = 1'b0;
        repeat (100) tick();
        key_raw_inc = 1'b1;
        repeat (15) tick();
        check("s6.norep_100", cnt_i0, 1);

        // 4: both pressed together, then inc released
        clear_counts();
        key_raw_inc = 1'b0;
        key_raw_dec = 1'b0;
        repeat (30) tick();
        check("s4.conflict", cf3, 1);
        check("s4.no_pulses", cnt_i3 + cnt_d3, 0);
        key_raw_inc = 1'b1;
        t_c = -1; t_p = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!cf3 && t_c < 0) t_c = tc;
            if (kd3 && t_p < 0) t_p = tc;
        end
        check("s4.resume_gap", t_p - t_c, RD + 1);
        key_raw_dec = 1'b1;
        repeat (15) tick();

        // 5: reset while held in DELAY, key still held afterwards
        clear_counts();
        key_raw_inc = 1'b0;
        repeat (13) tick();
        rst = 1'b1;
        repeat (3) tick();
        check("s5.rst_clears", ki3 | hi3, 0);
        rst = 1'b0;
        t_r = tc;
        t_p = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ki3 && t_p < 0) t_p = tc;
        end
        check("s5.latency", t_p - t_r, D + 4);
        key_raw_inc = 1'b1;
        repeat (15) tick();

        // Random key activity with occasional reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) key_raw_inc = ~key_raw_inc;
            if ($urandom_range(0, 11) == 0) key_raw_dec = ~key_raw_dec;
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
